// File: rtl/rgb_ccm.sv
// Colour correction matrix: signed 3x3 matrix plus per-channel offset on a multi-pixel RGB stream.
// Coefficients are double-buffered; a committed shadow set is copied to the active set only while vsync is low.
module rgb_ccm #(
   parameter int PW    = 8,
   parameter int PCNT  = 2,
   parameter int CW    = 12,
   parameter int FRAC  = 8,
   parameter int X_WID = 11
) (
   input  logic               i_pclk,
   input  logic               i_rstn,
   input  logic               i_vsync,
   input  logic               i_hsync,
   input  logic               i_de,
   input  logic               i_valid,
   input  logic [X_WID-1:0]   i_x_cnt,
   input  logic [X_WID-1:0]   i_y_cnt,
   input  logic [PW*PCNT-1:0] i_r,
   input  logic [PW*PCNT-1:0] i_g,
   input  logic [PW*PCNT-1:0] i_b,
   input  logic               i_cfg_we,
   input  logic [3:0]         i_cfg_addr,
   input  logic [CW-1:0]      i_cfg_wdata,
   input  logic               i_cfg_commit,
   output logic               o_cfg_pending,
   output logic               o_vsync,
   output logic               o_hsync,
   output logic               o_de,
   output logic               o_valid,
   output logic [X_WID-1:0]   o_x_cnt,
   output logic [X_WID-1:0]   o_y_cnt,
   output logic [PW*PCNT-1:0] o_r,
   output logic [PW*PCNT-1:0] o_g,
   output logic [PW*PCNT-1:0] o_b
);
   localparam int PRW   = PW + 1 + CW;
   localparam int SW    = PW + CW + 4;
   localparam int NCOEF = 12;
   localparam logic signed [CW-1:0] COEF_ONE = {{(CW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic signed [SW-1:0] ROUND    = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

   function automatic logic signed [CW-1:0] ident_coef(input int idx);
      logic signed [CW-1:0] v;
      case (idx)
         32'sd0, 32'sd4, 32'sd8: v = COEF_ONE;
         default:                v = {CW{1'b0}};
      endcase
      return v;
   endfunction

   function automatic logic [PW-1:0] shift_clamp(input logic signed [SW-1:0] acc);
      logic signed [SW-1:0] sh;
      logic [PW-1:0]        v;
      sh = acc >>> FRAC;
      if (sh[SW-1])
         v = {PW{1'b0}};
      else if (|sh[SW-2:PW])
         v = {PW{1'b1}};
      else
         v = sh[PW-1:0];
      return v;
   endfunction

   logic signed [CW-1:0] shadow_r [0:NCOEF-1];
   logic signed [CW-1:0] active_r [0:NCOEF-1];
   logic                 pending_r;
   logic                 apply_s;

   assign apply_s       = pending_r && !i_vsync;
   assign o_cfg_pending = pending_r;

   // Shadow writes every cycle; a commit arriving on an apply cycle re-arms pending so that cycle's write is not lost.
   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 0; k < NCOEF; k++) begin
            shadow_r[k] <= ident_coef(k);
            active_r[k] <= ident_coef(k);
         end
         pending_r <= 1'b0;
      end else begin
         for (int k = 0; k < NCOEF; k++) begin
            if (i_cfg_we && i_cfg_addr == 4'(k))
               shadow_r[k] <= i_cfg_wdata;
            if (apply_s)
               active_r[k] <= shadow_r[k];
         end
         if (i_cfg_commit)
            pending_r <= 1'b1;
         else if (apply_s)
            pending_r <= 1'b0;
      end
   end

   logic [2:0]       vs_r, hs_r, de_r, va_r;
   logic [X_WID-1:0] x_r [0:2];
   logic [X_WID-1:0] y_r [0:2];
   logic             ld1_s, ld2_s, ld3_s;

   assign ld1_s = i_de && i_valid;
   assign ld2_s = de_r[0] && va_r[0];
   assign ld3_s = de_r[1] && va_r[1];

   // Unconditional 3-deep delay line for sync and position.
   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) begin
         vs_r <= 3'b000;
         hs_r <= 3'b000;
         de_r <= 3'b000;
         va_r <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            x_r[k] <= {X_WID{1'b0}};
            y_r[k] <= {X_WID{1'b0}};
         end
      end else begin
         vs_r <= {vs_r[1:0], i_vsync};
         hs_r <= {hs_r[1:0], i_hsync};
         de_r <= {de_r[1:0], i_de};
         va_r <= {va_r[1:0], i_valid};
         x_r[0] <= i_x_cnt;
         y_r[0] <= i_y_cnt;
         for (int k = 1; k < 3; k++) begin
            x_r[k] <= x_r[k-1];
            y_r[k] <= y_r[k-1];
         end
      end
   end

   assign o_vsync = vs_r[2];
   assign o_hsync = hs_r[2];
   assign o_de    = de_r[2];
   assign o_valid = va_r[2];
   assign o_x_cnt = x_r[2];
   assign o_y_cnt = y_r[2];

   for (genvar l = 0; l < PCNT; l++) begin : g_lane
      logic [PW-1:0]         comp_s [0:2];
      logic signed [PRW-1:0] prod_r [0:8];
      logic signed [CW-1:0]  off_r  [0:2];
      logic signed [SW-1:0]  sum_r  [0:2];
      logic [PW-1:0]         pix_r  [0:2];

      assign comp_s[0] = i_r[l*PW +: PW];
      assign comp_s[1] = i_g[l*PW +: PW];
      assign comp_s[2] = i_b[l*PW +: PW];

      // Offsets are captured with the products so the whole pixel uses one coefficient set.
      always_ff @(posedge i_pclk or negedge i_rstn) begin
         if (!i_rstn) begin
            for (int k = 0; k < 9; k++)
               prod_r[k] <= {PRW{1'b0}};
            for (int c = 0; c < 3; c++)
               off_r[c] <= {CW{1'b0}};
         end else if (ld1_s) begin
            for (int k = 0; k < 9; k++)
               prod_r[k] <= PRW'($signed({1'b0, comp_s[k % 3]})) * PRW'(active_r[k]);
            for (int c = 0; c < 3; c++)
               off_r[c] <= active_r[9 + c];
         end
      end

      always_ff @(posedge i_pclk or negedge i_rstn) begin
         if (!i_rstn) begin
            for (int c = 0; c < 3; c++) begin
               sum_r[c] <= {SW{1'b0}};
               pix_r[c] <= {PW{1'b0}};
            end
         end else begin
            for (int c = 0; c < 3; c++) begin
               if (ld2_s)
                  sum_r[c] <= SW'(prod_r[3*c]) + SW'(prod_r[3*c+1]) + SW'(prod_r[3*c+2])
                            + (SW'(off_r[c]) <<< FRAC) + ROUND;
               if (ld3_s)
                  pix_r[c] <= shift_clamp(sum_r[c]);
            end
         end
      end

      assign o_r[l*PW +: PW] = pix_r[0];
      assign o_g[l*PW +: PW] = pix_r[1];
      assign o_b[l*PW +: PW] = pix_r[2];
   end

endmodule

// File: tb/tb_rgb_ccm.sv
// Self-checking bench for rgb_ccm: directed scenarios plus randomized traffic against a
// matrix-arithmetic reference model with a 3-cycle expectation history.
module tb_rgb_ccm;
   localparam int PW = 8, PCNT = 2, CW = 12, FRAC = 8, X_WID = 11;

   logic               i_pclk = 1'b0;
   logic               i_rstn = 1'b0;
   logic               i_vsync, i_hsync, i_de, i_valid;
   logic [X_WID-1:0]   i_x_cnt, i_y_cnt;
   logic [PW*PCNT-1:0] i_r, i_g, i_b;
   logic               i_cfg_we, i_cfg_commit;
   logic [3:0]         i_cfg_addr;
   logic [CW-1:0]      i_cfg_wdata;
   logic               o_cfg_pending, o_vsync, o_hsync, o_de, o_valid;
   logic [X_WID-1:0]   o_x_cnt, o_y_cnt;
   logic [PW*PCNT-1:0] o_r, o_g, o_b;

   rgb_ccm #(.PW(PW), .PCNT(PCNT), .CW(CW), .FRAC(FRAC), .X_WID(X_WID)) dut (
      .i_pclk(i_pclk), .i_rstn(i_rstn), .i_vsync(i_vsync), .i_hsync(i_hsync),
      .i_de(i_de), .i_valid(i_valid), .i_x_cnt(i_x_cnt), .i_y_cnt(i_y_cnt),
      .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
      .i_cfg_wdata(i_cfg_wdata), .i_cfg_commit(i_cfg_commit), .o_cfg_pending(o_cfg_pending),
      .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_valid(o_valid),
      .o_x_cnt(o_x_cnt), .o_y_cnt(o_y_cnt), .o_r(o_r), .o_g(o_g), .o_b(o_b));

   always #5 i_pclk = ~i_pclk;

   typedef struct packed {
      logic vs, hs, de, va;
      logic [X_WID-1:0] x, y;
      logic [PW*PCNT-1:0] r, g, b;
   } snap_t;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    m_shadow [12];
   int    m_active [12];
   bit    m_pending;
   snap_t hist [3];
   snap_t exp_s;
   logic [PW*PCNT-1:0] last_r, last_g, last_b;

   function automatic snap_t dut_snap();
      return {o_vsync, o_hsync, o_de, o_valid, o_x_cnt, o_y_cnt, o_r, o_g, o_b};
   endfunction

   function automatic int ident(int k);
      return (k == 0 || k == 4 || k == 8) ? 256 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 12; k++) begin
         m_shadow[k] = ident(k);
         m_active[k] = ident(k);
      end
      m_pending = 1'b0;
      for (int k = 0; k < 3; k++) hist[k] = '0;
      exp_s  = '0;
      last_r = '0; last_g = '0; last_b = '0;
   endtask

   // Corrected component: real-valued matrix product in 1/256 units, round half up, clamp to 0..255.
   function automatic logic [7:0] ref_pix(int row, int r, int g, int b);
      int acc;
      acc = m_active[row*3] * r + m_active[row*3+1] * g + m_active[row*3+2] * b
          + m_active[9+row] * 256 + 128;
      acc = acc >>> 8;
      if (acc < 0) return 8'd0;
      if (acc > 255) return 8'd255;
      return acc[7:0];
   endfunction

   // Advance one clock: model sees pre-edge inputs, config strobes are single-cycle pulses.
   task automatic cycle();
      snap_t s;
      bit    apply;
      if (i_de && i_valid)
         for (int l = 0; l < PCNT; l++) begin
            last_r[l*PW +: PW] = ref_pix(0, i_r[l*PW +: PW], i_g[l*PW +: PW], i_b[l*PW +: PW]);
            last_g[l*PW +: PW] = ref_pix(1, i_r[l*PW +: PW], i_g[l*PW +: PW], i_b[l*PW +: PW]);
            last_b[l*PW +: PW] = ref_pix(2, i_r[l*PW +: PW], i_g[l*PW +: PW], i_b[l*PW +: PW]);
         end
      s = {i_vsync, i_hsync, i_de, i_valid, i_x_cnt, i_y_cnt, last_r, last_g, last_b};
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
      apply = m_pending && !i_vsync;
      if (apply) m_active = m_shadow;
      if (i_cfg_we && i_cfg_addr < 4'd12) m_shadow[i_cfg_addr] = $signed(i_cfg_wdata);
      m_pending = i_cfg_commit || (m_pending && !apply);
      @(posedge i_pclk);
      #1;
      i_cfg_we = 1'b0;
      i_cfg_commit = 1'b0;
      exp_s = hist[2];
   endtask

   task automatic drive_rand(input bit vs);
      i_vsync = vs;
      i_hsync = 1'($urandom_range(0, 1));
      i_de    = ($urandom_range(0, 3) != 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_x_cnt = X_WID'($urandom);
      i_y_cnt = X_WID'($urandom);
      i_r = PCNT*PW'($urandom); i_g = PCNT*PW'($urandom); i_b = PCNT*PW'($urandom);
   endtask

   task automatic set_coef(input int a, input int v);
      i_de = 1'b0;
      i_cfg_we = 1'b1;
      i_cfg_addr = a[3:0];
      i_cfg_wdata = v[CW-1:0];
      cycle();
   endtask

   task automatic commit_blank();
      i_vsync = 1'b0; i_de = 1'b0;
      i_cfg_commit = 1'b1;
      cycle();
      cycle();
   endtask

   task automatic put_pix(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      i_vsync = 1'b1; i_de = 1'b1; i_valid = 1'b1;
      i_r = r; i_g = g; i_b = b;
      cycle();
      i_de = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge i_pclk);
      #1;
      n_cmp++; if (dut_snap() !== snap_t'(0)) begin n_bad++; $display("FAIL reset_out: got %h want 0", dut_snap()); end
      n_cmp++; if (o_cfg_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", o_cfg_pending); end
      i_rstn = 1'b1;
   endtask

   task automatic test_identity();
      i_vsync = 1'b1; i_hsync = 1'b1; i_de = 1'b1; i_valid = 1'b1;
      i_x_cnt = 11'd0; i_y_cnt = 11'd5;
      i_r = {8'd255, 8'd10}; i_g = {8'd0, 8'd20}; i_b = {8'd128, 8'd30};
      cycle();
      i_de = 1'b0; i_x_cnt = 11'd2;
      cycle();
      cycle();
      n_cmp++; if ({o_r, o_g, o_b} !== {16'hFF0A, 16'h0014, 16'h801E}) begin n_bad++;
         $display("FAIL identity_data: got %h want %h", {o_r, o_g, o_b}, {16'hFF0A, 16'h0014, 16'h801E}); end
      n_cmp++; if ({o_vsync, o_hsync, o_de, o_valid, o_x_cnt, o_y_cnt} !== {4'b1111, 11'd0, 11'd5}) begin n_bad++;
         $display("FAIL identity_sync: got %b%b%b%b x=%0d y=%0d want 1111 x=0 y=5", o_vsync, o_hsync, o_de, o_valid, o_x_cnt, o_y_cnt); end
      repeat (30) begin
         drive_rand(1'b1);
         cycle();
         n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL identity_rand: got %h want %h", dut_snap(), exp_s); end
      end
   endtask

   task automatic test_rounding();
      set_coef(0, 384);
      commit_blank();
      put_pix({8'd1, 8'd3}, 16'd0, 16'd0);
      n_cmp++; if ({o_r, o_g, o_b} !== {8'd2, 8'd5, 32'd0}) begin n_bad++;
         $display("FAIL rounding: got r=%h g=%h b=%h want r=0205 g=0 b=0", o_r, o_g, o_b); end
      n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL rounding_model: got %h want %h", dut_snap(), exp_s); end
   endtask

   task automatic test_saturation();
      set_coef(0, 512);
      commit_blank();
      put_pix({8'd100, 8'd200}, 16'd0, 16'd0);
      n_cmp++; if (o_r !== {8'd200, 8'd255}) begin n_bad++; $display("FAIL sat_high: got %h want c8ff", o_r); end
      set_coef(0, 256);
      set_coef(1, -256);
      commit_blank();
      put_pix({8'd60, 8'd10}, {8'd50, 8'd50}, 16'd0);
      n_cmp++; if ({o_r, o_g} !== {8'd10, 8'd0, 8'd50, 8'd50}) begin n_bad++;
         $display("FAIL sat_neg: got r=%h g=%h want r=0a00 g=3232", o_r, o_g); end
      set_coef(1, 0);
      set_coef(9, -5);
      commit_blank();
      put_pix({8'd100, 8'd3}, 16'd0, 16'd0);
      n_cmp++; if (o_r !== {8'd95, 8'd0}) begin n_bad++; $display("FAIL sat_offset: got %h want 5f00", o_r); end
      n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL sat_model: got %h want %h", dut_snap(), exp_s); end
   endtask

   task automatic test_commit_timing();
      i_vsync = 1'b1;
      set_coef(9, 0);
      drive_rand(1'b1);
      i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_wdata = 12'd0; i_cfg_commit = 1'b1;
      cycle();
      n_cmp++; if (o_cfg_pending !== 1'b1) begin n_bad++; $display("FAIL commit_pend_set: got %b want 1", o_cfg_pending); end
      repeat (12) begin
         drive_rand(1'b1);
         cycle();
         n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL commit_hold_data: got %h want %h", dut_snap(), exp_s); end
         n_cmp++; if (o_cfg_pending !== 1'b1) begin n_bad++; $display("FAIL commit_hold_pend: got %b want 1", o_cfg_pending); end
      end
      drive_rand(1'b0);
      cycle();
      n_cmp++; if (o_cfg_pending !== 1'b0) begin n_bad++; $display("FAIL commit_apply_pend: got %b want 0", o_cfg_pending); end
      repeat (3) begin
         drive_rand(1'b1);
         i_de = 1'b1; i_valid = 1'b1;
         cycle();
      end
      n_cmp++; if (o_r !== 16'd0) begin n_bad++; $display("FAIL commit_new_frame: got %h want 0000", o_r); end
      n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL commit_model: got %h want %h", dut_snap(), exp_s); end
   endtask

   task automatic test_simultaneous();
      drive_rand(1'b1);
      i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_wdata = 12'd300; i_cfg_commit = 1'b1;
      cycle();
      repeat (5) begin drive_rand(1'b1); cycle(); end
      drive_rand(1'b0);
      cycle();
      put_pix({8'd100, 8'd100}, 16'd0, 16'd0);
      n_cmp++; if (o_r !== {8'd117, 8'd117}) begin n_bad++; $display("FAIL simul_write_commit: got %h want 7575", o_r); end
      drive_rand(1'b1);
      i_cfg_commit = 1'b1;
      cycle();
      repeat (3) begin drive_rand(1'b1); cycle(); end
      drive_rand(1'b0);
      i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_wdata = 12'd128;
      cycle();
      n_cmp++; if (o_cfg_pending !== 1'b0) begin n_bad++; $display("FAIL simul_apply_pend: got %b want 0", o_cfg_pending); end
      put_pix({8'd100, 8'd100}, 16'd0, 16'd0);
      n_cmp++; if (o_r !== {8'd117, 8'd117}) begin n_bad++; $display("FAIL simul_write_at_apply: got %h want 7575", o_r); end
      commit_blank();
      put_pix({8'd100, 8'd100}, 16'd0, 16'd0);
      n_cmp++; if (o_r !== {8'd50, 8'd50}) begin n_bad++; $display("FAIL simul_shadow_kept: got %h want 3232", o_r); end
   endtask

   task automatic test_back_to_back();
      bit vs = 1'b1;
      int left = 10;
      repeat (300) begin
         if (left == 0) begin
            vs = ~vs;
            left = vs ? $urandom_range(10, 25) : $urandom_range(1, 4);
         end
         left--;
         drive_rand(vs);
         i_cfg_we = ($urandom_range(0, 3) == 0);
         i_cfg_addr = 4'($urandom);
         i_cfg_wdata = CW'($urandom);
         i_cfg_commit = ($urandom_range(0, 9) == 0);
         cycle();
         n_cmp++; if (dut_snap() !== exp_s) begin n_bad++; $display("FAIL b2b_data: got %h want %h", dut_snap(), exp_s); end
         n_cmp++; if (o_cfg_pending !== m_pending) begin n_bad++; $display("FAIL b2b_pend: got %b want %b", o_cfg_pending, m_pending); end
      end
   endtask

   task automatic test_reset_mid_frame();
      set_coef(4, 100);
      commit_blank();
      drive_rand(1'b1);
      i_cfg_commit = 1'b1;
      cycle();
      repeat (4) begin drive_rand(1'b1); i_de = 1'b1; i_valid = 1'b1; cycle(); end
      #2;
      i_rstn = 1'b0;
      #1;
      n_cmp++; if (dut_snap() !== snap_t'(0)) begin n_bad++; $display("FAIL midrst_out: got %h want 0", dut_snap()); end
      n_cmp++; if (o_cfg_pending !== 1'b0) begin n_bad++; $display("FAIL midrst_pend: got %b want 0", o_cfg_pending); end
      @(posedge i_pclk);
      #1;
      model_reset();
      i_rstn = 1'b1;
   endtask

   initial begin
      i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_valid = 1'b0;
      i_x_cnt = '0; i_y_cnt = '0; i_r = '0; i_g = '0; i_b = '0;
      i_cfg_we = 1'b0; i_cfg_addr = 4'd0; i_cfg_wdata = '0; i_cfg_commit = 1'b0;
      model_reset();
      test_reset();
      test_identity();
      test_rounding();
      test_saturation();
      test_commit_timing();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_frame();
      test_identity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
